// File: rtl/decim_stream_arbiter.sv
// decim_stream_arbiter: round-robin burst arbiter that feeds two sample streams into one decimator.
// Define DECIM_ARB_TIMEOUT_EN to compile in the stall timeout that aborts a starved burst.
module decim_stream_arbiter #(
   parameter int W         = 16,
   parameter int BURST_LEN = 4,
   parameter int TIMEOUT   = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         s0_valid,
   input  logic         s1_valid,
   output logic         s0_ready,
   output logic         s1_ready,
   input  logic [W-1:0] s0_data,
   input  logic [W-1:0] s1_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [W-1:0] m_data,
   output logic         m_chan,
   output logic         m_last,
   output logic [1:0]   grant,
   output logic         burst_abort
);

   localparam int CW = $clog2(BURST_LEN);

   if (BURST_LEN < 2 || TIMEOUT < 2) begin : g_bad_params
      $error("decim_stream_arbiter: BURST_LEN and TIMEOUT must be at least 2");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic            r_last_srv;
   logic [1:0]      r_grant;
   logic            r_chan;

   logic            w_sel_valid;
   logic            w_other_valid;
   logic            w_xfer;
   logic            w_done;
   logic            w_abort;

   // Handshake: a sample moves when m_valid && m_ready in the same cycle; the granted
   // requester sees m_ready directly as its ready, the other requester always sees 0.
   always_comb begin
      w_sel_valid   = 1'b0;
      w_other_valid = 1'b0;
      m_data        = '0;
      s0_ready      = 1'b0;
      s1_ready      = 1'b0;
      case (r_state)
         GNT0: begin
            w_sel_valid   = s0_valid;
            w_other_valid = s1_valid;
            m_data        = s0_data;
            s0_ready      = m_ready;
         end
         GNT1: begin
            w_sel_valid   = s1_valid;
            w_other_valid = s0_valid;
            m_data        = s1_data;
            s1_ready      = m_ready;
         end
         default: begin
            w_sel_valid   = 1'b0;
            w_other_valid = 1'b0;
         end
      endcase
   end

   assign m_valid = w_sel_valid;
   assign w_xfer  = w_sel_valid & m_ready;
   assign w_done  = w_xfer && (r_cnt == CW'(BURST_LEN - 1));
   assign m_last  = w_done;
   assign grant   = r_grant;
   assign m_chan  = r_chan;

`ifdef DECIM_ARB_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT);
   logic [SW-1:0] r_stall;

   // Abort fires during the TIMEOUT-th consecutive starved cycle of a grant.
   assign w_abort = (r_state != IDLE) && !w_sel_valid && (r_stall == SW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall <= '0;
      end else if (r_state == IDLE || w_sel_valid || w_abort) begin
         r_stall <= '0;
      end else begin
         r_stall <= r_stall + 1'b1;
      end
   end
`else
   assign w_abort = 1'b0;
`endif

   assign burst_abort = w_abort;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (s0_valid && s1_valid) begin
               w_next = r_last_srv ? GNT0 : GNT1;
            end else if (s0_valid) begin
               w_next = GNT0;
            end else if (s1_valid) begin
               w_next = GNT1;
            end
         end
         GNT0, GNT1: begin
            if (w_abort) begin
               w_next = IDLE;
            end else if (w_done) begin
               if (w_other_valid) begin
                  w_next = (r_state == GNT0) ? GNT1 : GNT0;
               end else if (w_sel_valid) begin
                  w_next = r_state;
               end else begin
                  w_next = IDLE;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // r_last_srv = 1 means s1 was served last, so s0 wins the next contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_grant    <= 2'b00;
         r_chan     <= 1'b0;
         r_cnt      <= '0;
         r_last_srv <= 1'b1;
      end else begin
         r_state <= w_next;
         r_grant <= {w_next == GNT1, w_next == GNT0};
         r_chan  <= (w_next == GNT1);
         if (w_abort || w_done) begin
            r_cnt      <= '0;
            r_last_srv <= (r_state == GNT1);
         end else if (w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule
